// File: rtl/rr_mux.sv
// Registered N-channel multiplexer with valid/ready handshakes.
// The channel comes from an explicit select (mode 0) or from a round-robin arbiter (mode 1).
module rr_mux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;

  logic             slot_free;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             transfer;

  assign slot_free = !valid_q || out_ready;

  // Search starts at ptr and wraps; the first valid channel wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (!rr_found && in_valid[(int'(ptr_q) + k) % int'(CHANNELS)]) begin
        rr_found = 1'b1;
        rr_idx   = SEL_W'((int'(ptr_q) + k) % int'(CHANNELS));
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (mode) begin
      grant_valid = rr_found;
      grant_idx   = rr_idx;
    end else if (int'(sel) < int'(CHANNELS)) begin
      grant_valid = in_valid[sel];
      grant_idx   = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_valid) begin
      in_ready[grant_idx] = slot_free;
    end
  end

  assign transfer = grant_valid && slot_free;

  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    if (transfer) begin
      data_d  = in_data[int'(grant_idx)*int'(WIDTH) +: WIDTH];
      chan_d  = grant_idx;
      valid_d = 1'b1;
      if (mode) begin
        ptr_d = (int'(grant_idx) == int'(CHANNELS) - 1) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// Directed self-checking bench for rr_mux (WIDTH=8, CHANNELS=4).
module tb_rr_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;

  int checks = 0;
  int failures = 0;

  rr_mux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_exp[4];
    int sp_exp[4];
    rr_exp = '{0, 1, 2, 3};
    sp_exp = '{1, 3, 1, 3};

    rst       = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    #2;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'h00);
    check_eq("rst_chan", 32'(out_chan), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'b0001);
    step();
    rst = 1'b0;

    // Fixed-select sweep.
    in_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check_eq("fix_in_ready", 32'(in_ready), 32'(1 << s));
      step();
      check_eq("fix_valid", 32'(out_valid), 32'd1);
      check_eq("fix_data", 32'(out_data), 32'(8'h11 * (s + 1)));
      check_eq("fix_chan", 32'(out_chan), 32'(s));
    end

    // Round-robin fairness with wrap; ptr still 0 after mode-0 traffic.
    mode = 1'b1;
    #1;
    check_eq("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq("rr_valid", 32'(out_valid), 32'd1);
      check_eq("rr_chan", 32'(out_chan), 32'(rr_exp[i % 4]));
    end

    // Sparse round-robin: ptr = 1 here.
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("sparse_chan", 32'(out_chan), 32'(sp_exp[i]));
      check_eq("sparse_data", 32'(out_data), 32'(8'h11 * (sp_exp[i] + 1)));
    end
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("only1_chan", 32'(out_chan), 32'd1);
      check_eq("only1_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure: ptr = 2, holding ch1 word.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    check_eq("bp_in_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_data", 32'(out_data), 32'h22);
      check_eq("bp_chan", 32'(out_chan), 32'd1);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready), 32'b0100);
    step();
    check_eq("bp_next_chan", 32'(out_chan), 32'd2);
    check_eq("bp_next_data", 32'(out_data), 32'h33);
    step();
    check_eq("bp_after_chan", 32'(out_chan), 32'd3);

    // Mode switch to fixed select on an idle channel; ptr = 0 now.
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1011;
    #1;
    check_eq("ms_in_ready", 32'(in_ready), 32'd0);
    step();
    check_eq("ms_drain_valid", 32'(out_valid), 32'd0);
    check_eq("ms_hold_chan", 32'(out_chan), 32'd3);
    step();
    check_eq("ms_idle_valid", 32'(out_valid), 32'd0);
    in_valid = 4'b1111;
    #1;
    check_eq("ms_ready2", 32'(in_ready), 32'b0100);
    step();
    check_eq("ms_chan2", 32'(out_chan), 32'd2);
    check_eq("ms_data2", 32'(out_data), 32'h33);
    mode = 1'b1;
    #1;
    check_eq("ms_ptr_kept", 32'(in_ready), 32'b0001);

    // Advance ptr, then reset mid-stream with a held word.
    step();
    step();
    check_eq("pre_rst_chan", 32'(out_chan), 32'd1);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_data", 32'(out_data), 32'h00);
    check_eq("mid_rst_chan", 32'(out_chan), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'b0001);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("post_rst_chan", 32'(out_chan), 32'd0);
    check_eq("post_rst_data", 32'(out_data), 32'h11);
    check_eq("post_rst_valid", 32'(out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
